uop_seq_decoder: RTL

UOP_SEQ_DECODER -- requirements
Module: uop_seq_decoder

---
 rtl/uop_dec_pkg.sv | 77 +++++++
 rtl/uop_sat_counter.sv | 45 ++++
 rtl/uop_seq_decoder.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/uop_dec_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uop_dec_pkg
//  Description : Shared types, opcode decode table and lookup function for
//                the micro-op sequence decoder.
//                Each table entry carries a legal flag, a micro-op count
//                (1..8) and a 64-bit control base. The top module narrows the
//                control base to its CTRL_W and clamps the count to SEQ_MAX.
//                Opcodes beyond the table depth decode as illegal.
//  Revision    : 1.0  initial release
// ============================================================================
package uop_dec_pkg;

    localparam int c_TBL_DEPTH  = 32;
    localparam int c_TBL_IDX_W  = 5;
    localparam int c_TBL_CTRL_W = 64;

    typedef struct packed {
        logic                    legal;
        logic [3:0]              n_uop;
        logic [c_TBL_CTRL_W-1:0] ctrl_base;
    } uop_entry_t;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } uop_state_t;

    // {legal, n_uop, ctrl_base}; illegal rows keep n_uop=1 so a stray read
    // can never request a zero-length sequence.
    localparam uop_entry_t DECODE_TABLE [c_TBL_DEPTH] = '{
        {1'b1, 4'd1, 64'h00_0000_0100},  // 0
        {1'b1, 4'd3, 64'h00_0000_0010},  // 1
        {1'b1, 4'd4, 64'h40_0000_0020},  // 2
        {1'b1, 4'd2, 64'h7F_FFFF_FFF0},  // 3
        {1'b1, 4'd1, 64'h12_3456_789A},  // 4
        {1'b0, 4'd1, 64'h00_0000_0000},  // 5
        {1'b1, 4'd2, 64'h00_0000_0C00},  // 6
        {1'b1, 4'd3, 64'h00_0000_00FF},  // 7
        {1'b1, 4'd4, 64'h55_5555_5555},  // 8
        {1'b1, 4'd1, 64'h2A_AAAA_AAAA},  // 9
        {1'b1, 4'd2, 64'h00_0000_0003},  // 10
        {1'b0, 4'd1, 64'h00_0000_0000},  // 11
        {1'b1, 4'd3, 64'h0F_0F0F_0F0F},  // 12
        {1'b1, 4'd4, 64'h70_0000_0007},  // 13
        {1'b1, 4'd1, 64'h00_0000_0000},  // 14
        {1'b1, 4'd2, 64'h10_0000_0001},  // 15
        {1'b1, 4'd1, 64'h00_00AB_CDEF},  // 16
        {1'b0, 4'd1, 64'h00_0000_0000},  // 17
        {1'b1, 4'd4, 64'h33_3333_3333},  // 18
        {1'b1, 4'd3, 64'h44_4444_4444},  // 19
        {1'b1, 4'd2, 64'h66_6666_6666},  // 20
        {1'b1, 4'd1, 64'h77_7777_7777},  // 21
        {1'b1, 4'd4, 64'h00_0000_0008},  // 22
        {1'b0, 4'd1, 64'h00_0000_0000},  // 23
        {1'b1, 4'd3, 64'h01_2345_6789},  // 24
        {1'b1, 4'd2, 64'h11_2233_4455},  // 25
        {1'b1, 4'd1, 64'h66_7700_1122},  // 26
        {1'b1, 4'd4, 64'h00_DEAD_BEEF},  // 27
        {1'b1, 4'd2, 64'h0B_ADC0_FFEE},  // 28
        {1'b0, 4'd1, 64'h00_0000_0000},  // 29
        {1'b1, 4'd3, 64'h7F_0000_0000},  // 30
        {1'b0, 4'd1, 64'h00_0000_0000}   // 31
    };

    function automatic uop_entry_t decode_op(input logic [31:0] op);
        uop_entry_t e;
        if (op < 32'(c_TBL_DEPTH)) begin
            e = DECODE_TABLE[op[c_TBL_IDX_W-1:0]];
        end else begin
            e = '0;
        end
        return e;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uop_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : uop_sat_counter
//  Description : Saturating up-counter with synchronous clear.
//                Clear wins over increment; the count sticks at all-ones.
//  Ports       : clk, rst  - clock, synchronous active-high reset
//                clr       - force count to zero
//                inc       - add one unless saturated
//                cnt       - current count
//  Revision    : 1.0  initial release
// ============================================================================
module uop_sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt
);

    logic [WIDTH-1:0] r_cnt_q;
    logic [WIDTH-1:0] w_cnt_d;

    always_comb begin
        w_cnt_d = r_cnt_q;
        if (clr) begin
            w_cnt_d = '0;
        end else if (inc && (r_cnt_q != {WIDTH{1'b1}})) begin
            w_cnt_d = r_cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt_q <= '0;
        end else begin
            r_cnt_q <= w_cnt_d;
        end
    end

    assign cnt = r_cnt_q;

endmodule
`default_nettype wire

// File: rtl/uop_seq_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : uop_seq_decoder
//  Description : Expands each accepted opcode into a sequence of micro-op
//                beats looked up in DECODE_TABLE. Legal opcodes yield n_uop
//                beats whose control word is ctrl_base XOR beat index;
//                illegal opcodes yield one flagged beat and bump a
//                saturating counter. Outputs are registered; the first beat
//                appears the cycle after accept, and a new opcode may be
//                accepted while the previous last beat transfers.
//  Ports       : clk, rst               - clock, sync active-high reset
//                in_valid/in_ready      - opcode handshake (in_op, in_tag)
//                out_valid/out_ready    - beat handshake
//                out_ctrl, out_uop_idx, out_last, out_illegal, out_tag
//                illegal_cnt, cnt_clr   - illegal-opcode counter and clear
//                busy                   - sequencer in ISSUE state
//  Notes       : OP_W <= 32, CTRL_W <= 64, SEQ_MAX in 1..8.
//  Revision    : 1.0  initial release
// ============================================================================
module uop_seq_decoder
    import uop_dec_pkg::*;
#(
    parameter int OP_W    = 5,
    parameter int CTRL_W  = 39,
    parameter int SEQ_MAX = 4,
    parameter int TAG_W   = 4,
    parameter int CNT_W   = 8,
    localparam int IDX_W  = (SEQ_MAX > 1) ? $clog2(SEQ_MAX) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_op,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [IDX_W-1:0]  out_uop_idx,
    output logic              out_last,
    output logic              out_illegal,
    output logic [TAG_W-1:0]  out_tag,
    output logic [CNT_W-1:0]  illegal_cnt,
    input  logic              cnt_clr,
    output logic              busy
);

    uop_state_t        r_state_q,     w_state_d;
    logic              r_out_valid_q, w_out_valid_d;
    logic [CTRL_W-1:0] r_out_ctrl_q,  w_out_ctrl_d;
    logic [IDX_W-1:0]  r_idx_q,       w_idx_d;
    logic              r_last_q,      w_last_d;
    logic              r_illegal_q,   w_illegal_d;
    logic [TAG_W-1:0]  r_tag_q,       w_tag_d;
    logic [CTRL_W-1:0] r_base_q,      w_base_d;
    logic [IDX_W-1:0]  r_last_idx_q,  w_last_idx_d;

    uop_entry_t        w_entry;
    logic [3:0]        w_n_uop;
    logic [IDX_W-1:0]  w_idx_nxt;
    logic              w_accept;
    logic              w_xfer;
    logic              w_illegal_acc;

    // Ready whenever nothing is pending or the pending beat is the last one
    // and leaves this cycle, so sequences chain without a bubble.
    assign in_ready      = !r_out_valid_q || (out_ready && r_last_q);
    assign w_accept      = in_valid && in_ready;
    assign w_xfer        = r_out_valid_q && out_ready;

    assign w_entry       = decode_op(32'(in_op));
    assign w_illegal_acc = w_accept && !w_entry.legal;
    assign w_idx_nxt     = r_idx_q + IDX_W'(1);

    // Guard against table rows that exceed this instance's SEQ_MAX or hold 0.
    always_comb begin
        w_n_uop = w_entry.n_uop;
        if (w_n_uop == 4'd0) begin
            w_n_uop = 4'd1;
        end else if (w_n_uop > 4'(SEQ_MAX)) begin
            w_n_uop = 4'(SEQ_MAX);
        end
    end

    always_comb begin
        w_state_d     = r_state_q;
        w_out_valid_d = r_out_valid_q;
        w_out_ctrl_d  = r_out_ctrl_q;
        w_idx_d       = r_idx_q;
        w_last_d      = r_last_q;
        w_illegal_d   = r_illegal_q;
        w_tag_d       = r_tag_q;
        w_base_d      = r_base_q;
        w_last_idx_d  = r_last_idx_q;

        if (w_accept) begin
            w_state_d     = ST_ISSUE;
            w_out_valid_d = 1'b1;
            w_idx_d       = '0;
            w_tag_d       = in_tag;
            if (w_entry.legal) begin
                // Index 0 XOR leaves the base untouched.
                w_base_d     = CTRL_W'(w_entry.ctrl_base);
                w_out_ctrl_d = CTRL_W'(w_entry.ctrl_base);
                w_last_idx_d = IDX_W'(w_n_uop - 4'd1);
                w_last_d     = (w_n_uop == 4'd1);
                w_illegal_d  = 1'b0;
            end else begin
                w_base_d     = '0;
                w_out_ctrl_d = '0;
                w_last_idx_d = '0;
                w_last_d     = 1'b1;
                w_illegal_d  = 1'b1;
            end
        end else if (w_xfer) begin
            if (r_last_q) begin
                w_state_d     = ST_IDLE;
                w_out_valid_d = 1'b0;
            end else begin
                w_idx_d      = w_idx_nxt;
                w_out_ctrl_d = r_base_q ^ CTRL_W'(w_idx_nxt);
                w_last_d     = (w_idx_nxt == r_last_idx_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q     <= ST_IDLE;
            r_out_valid_q <= 1'b0;
            r_out_ctrl_q  <= '0;
            r_idx_q       <= '0;
            r_last_q      <= 1'b0;
            r_illegal_q   <= 1'b0;
            r_tag_q       <= '0;
            r_base_q      <= '0;
            r_last_idx_q  <= '0;
        end else begin
            r_state_q     <= w_state_d;
            r_out_valid_q <= w_out_valid_d;
            r_out_ctrl_q  <= w_out_ctrl_d;
            r_idx_q       <= w_idx_d;
            r_last_q      <= w_last_d;
            r_illegal_q   <= w_illegal_d;
            r_tag_q       <= w_tag_d;
            r_base_q      <= w_base_d;
            r_last_idx_q  <= w_last_idx_d;
        end
    end

    uop_sat_counter #(
        .WIDTH (CNT_W)
    ) u_illegal_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (w_illegal_acc),
        .cnt (illegal_cnt)
    );

    assign out_valid   = r_out_valid_q;
    assign out_ctrl    = r_out_ctrl_q;
    assign out_uop_idx = r_idx_q;
    assign out_last    = r_last_q;
    assign out_illegal = r_illegal_q;
    assign out_tag     = r_tag_q;
    assign busy        = (r_state_q == ST_ISSUE);

endmodule
`default_nettype wire
